// File: rtl/operand_fetch_if.sv
// operand_fetch_if: decode-side, regfile, write-back and execute-side signals of the operand fetch stage.
// Latency: none; plain wires grouped for port hookup.
// Backpressure: in_ready/out_ready carry the valid/ready handshakes on each side.
interface operand_fetch_if #(
  parameter int XLEN      = 32,
  parameter int PAYLOAD_W = 64
);
  // decode side
  logic                 in_valid;
  logic                 in_ready;
  logic [4:0]           in_rs1_s;
  logic [4:0]           in_rs2_s;
  logic [4:0]           in_rd_s;
  logic [PAYLOAD_W-1:0] in_payload;
  // regfile synchronous read port
  logic [4:0]           rf_rs1_s;
  logic [4:0]           rf_rs2_s;
  logic [XLEN-1:0]      rf_rs1_v;
  logic [XLEN-1:0]      rf_rs2_v;
  // write-back (same enable the regfile uses)
  logic                 wb_we;
  logic [4:0]           wb_rd_s;
  logic [XLEN-1:0]      wb_rd_v;
  // execute side
  logic                 out_valid;
  logic                 out_ready;
  logic [XLEN-1:0]      out_rs1_v;
  logic [XLEN-1:0]      out_rs2_v;
  logic [4:0]           out_rd_s;
  logic [PAYLOAD_W-1:0] out_payload;

  // environment view: decode, regfile, write-back and execute around the stage
  modport master (
    output in_valid, in_rs1_s, in_rs2_s, in_rd_s, in_payload,
    input  in_ready,
    input  rf_rs1_s, rf_rs2_s,
    output rf_rs1_v, rf_rs2_v,
    output wb_we, wb_rd_s, wb_rd_v,
    input  out_valid, out_rs1_v, out_rs2_v, out_rd_s, out_payload,
    output out_ready
  );

  // stage view
  modport slave (
    input  in_valid, in_rs1_s, in_rs2_s, in_rd_s, in_payload,
    output in_ready,
    output rf_rs1_s, rf_rs2_s,
    input  rf_rs1_v, rf_rs2_v,
    input  wb_we, wb_rd_s, wb_rd_v,
    output out_valid, out_rs1_v, out_rs2_v, out_rd_s, out_payload,
    input  out_ready
  );
endinterface

// File: rtl/operand_fetch.sv
// operand_fetch: register-read stage; P holds an op whose regfile read is in flight, O presents operands.
// Latency: accept at edge T -> out_valid from edge T+1; without OPFETCH_BYPASS_EN a write-back hit costs +1.
// Backpressure: in_ready falls when P cannot advance into O; O holds stable while out_ready is low.
module operand_fetch #(
  parameter int XLEN      = 32,
  parameter int PAYLOAD_W = 64
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           flush,
  operand_fetch_if.slave bus
);

  typedef struct packed {
    logic [4:0]           rs1_s;
    logic [4:0]           rs2_s;
    logic [4:0]           rd_s;
    logic [PAYLOAD_W-1:0] payload;
  } p_ent_t;

  typedef struct packed {
    logic [XLEN-1:0]      rs1_v;
    logic [XLEN-1:0]      rs2_v;
    logic [4:0]           rd_s;
    logic [PAYLOAD_W-1:0] payload;
  } o_ent_t;

  logic            p_v;
  p_ent_t          p_q;
  logic            o_v;
  o_ent_t          o_q;

  // registered write-back: the one write the regfile read in P may have missed
  logic            wbq_we;
  logic [4:0]      wbq_rd_s;
`ifdef OPFETCH_BYPASS_EN
  logic [XLEN-1:0] wbq_rd_v;
`endif

  logic            hit1;
  logic            hit2;
  logic            haz;
  logic            p_adv;
  logic            accept;
  logic [XLEN-1:0] op1;
  logic [XLEN-1:0] op2;

  // A registered write to a nonzero index that P sources; x0 is never matched
  always_comb begin
    hit1 = wbq_we && (wbq_rd_s == p_q.rs1_s) && (p_q.rs1_s != 5'd0);
    hit2 = wbq_we && (wbq_rd_s == p_q.rs2_s) && (p_q.rs2_s != 5'd0);
  end

`ifdef OPFETCH_BYPASS_EN
  // Forward the missed write straight into the operands; P never has to wait
  always_comb begin
    haz = 1'b0;
    op1 = hit1 ? wbq_rd_v : bus.rf_rs1_v;
    op2 = hit2 ? wbq_rd_v : bus.rf_rs2_v;
  end
`else
  // Hold P one cycle on a hit so its re-read sees the write that has now landed
  always_comb begin
    haz = p_v && (hit1 || hit2);
    op1 = bus.rf_rs1_v;
    op2 = bus.rf_rs2_v;
  end
`endif

  // P moves to O when O is free or draining this cycle and no hazard holds it
  assign p_adv  = p_v && (!o_v || bus.out_ready) && !haz;
  assign bus.in_ready = rst_n && !flush && (!p_v || p_adv);
  assign accept = bus.in_valid && bus.in_ready;

  // A stalled P keeps re-reading its own sources; otherwise read for the incoming op
  assign bus.rf_rs1_s = (p_v && !p_adv) ? p_q.rs1_s : bus.in_rs1_s;
  assign bus.rf_rs2_s = (p_v && !p_adv) ? p_q.rs2_s : bus.in_rs2_s;

  // Capture write-back every cycle so the next cycle can bypass or detect the hazard
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wbq_we   <= 1'b0;
      wbq_rd_s <= 5'd0;
`ifdef OPFETCH_BYPASS_EN
      wbq_rd_v <= '0;
`endif
    end else begin
      wbq_we   <= bus.wb_we;
      wbq_rd_s <= bus.wb_rd_s;
`ifdef OPFETCH_BYPASS_EN
      wbq_rd_v <= bus.wb_rd_v;
`endif
    end
  end

  // P entry: loads on accept, empties when it advances or on flush
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_v <= 1'b0;
      p_q <= '0;
    end else if (flush) begin
      p_v <= 1'b0;
    end else if (accept) begin
      p_v <= 1'b1;
      p_q <= '{rs1_s: bus.in_rs1_s, rs2_s: bus.in_rs2_s,
               rd_s: bus.in_rd_s, payload: bus.in_payload};
    end else if (p_adv) begin
      p_v <= 1'b0;
    end
  end

  // O entry: reloads whenever P advances (even while being consumed), clears on a bare consume
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_v <= 1'b0;
      o_q <= '0;
    end else if (flush) begin
      o_v <= 1'b0;
    end else if (p_adv) begin
      o_v <= 1'b1;
      o_q <= '{rs1_v: op1, rs2_v: op2, rd_s: p_q.rd_s, payload: p_q.payload};
    end else if (bus.out_ready) begin
      o_v <= 1'b0;
    end
  end

  assign bus.out_valid   = o_v;
  assign bus.out_rs1_v   = o_q.rs1_v;
  assign bus.out_rs2_v   = o_q.rs2_v;
  assign bus.out_rd_s    = o_q.rd_s;
  assign bus.out_payload = o_q.payload;

  // Execute must see an unchanging op while it is stalling the stage
  a_o_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (o_v && !bus.out_ready && !flush) |=> (o_v && $stable(o_q)));

endmodule
